// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART receive definitions: frame-checker state
//               encoding, default widths and the parity-check helper.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

   localparam int DEF_DATA_W = 8;
   localparam int DEF_CNT_W  = 8;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_DATA   = 3'd1,
      S_PARITY = 3'd2,
      S_STOP1  = 3'd3,
      S_STOP2  = 3'd4,
      S_REPORT = 3'd5
   } fc_state_t;

   // Parity is bad when the XOR of data and parity bit differs from the
   // selected sense (1 = odd, 0 = even).
   function automatic logic parity_mismatch(input logic data_xor,
                                            input logic par_bit,
                                            input logic odd);
      return (data_xor ^ par_bit) != odd;
   endfunction

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Event counter that saturates at all-ones; clear wins over
//               a coincident increment.
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   input  logic             clr,
   output logic [CNT_W-1:0] cnt
);

   logic [CNT_W-1:0] r_cnt;

   // Count events, holding at the maximum value once reached.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         r_cnt <= '0;
      end else if (inc && (r_cnt != '1)) begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   assign cnt = r_cnt;

endmodule
`default_nettype wire

// File: rtl/frame_check.sv
`default_nettype none
// ============================================================================
// Module      : frame_check
// Description : UART frame checker. Assembles data bits delivered by the
//               bit sampler, checks parity and stop bits, detects breaks,
//               and keeps sticky flags plus saturating error counters.
// Revision    : 1.0 - initial release
// ============================================================================
module frame_check
   import uart_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int CNT_W  = DEF_CNT_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              frame_start,
   input  logic              sample_valid,
   input  logic              sampled_bit,
   input  logic              cfg_par_en,
   input  logic              cfg_par_odd,
   input  logic              cfg_stop2,
   input  logic              clr_stats,
   output logic [DATA_W-1:0] rx_data,
   output logic              frame_done,
   output logic              data_valid,
   output logic              par_err,
   output logic              stp_err,
   output logic              brk_det,
   output logic              par_err_sticky,
   output logic              stp_err_sticky,
   output logic              brk_sticky,
   output logic [CNT_W-1:0]  par_err_cnt,
   output logic [CNT_W-1:0]  stp_err_cnt,
   output logic [CNT_W-1:0]  brk_cnt
);

   localparam int IDX_W = 4;

   fc_state_t         r_state;
   logic [IDX_W-1:0]  r_idx;
   logic [DATA_W-1:0] r_shift;
   logic [DATA_W-1:0] r_rx_data;
   logic              r_par_en;
   logic              r_par_odd;
   logic              r_stop2;
   logic              r_par_bit;
   logic              r_par_bad;
   logic              r_stp_bad;
   logic              r_brk;
   logic              r_done;
   logic              r_valid;
   logic              r_par_err;
   logic              r_stp_err;
   logic              r_brk_det;
   logic              r_par_sticky;
   logic              r_stp_sticky;
   logic              r_brk_sticky;

   logic              w_stop_bad;
   logic              w_brk_now;
   logic              w_finish;
   logic              w_brk_f;
   logic              w_par_f;
   logic              w_stp_f;

   // Final-frame verdict, resolved on the cycle of the last stop sample.
   // A break masks the parity and stop errors of the same frame.
   always_comb begin
      w_stop_bad = !sampled_bit;
      w_brk_now  = (r_shift == '0) && !r_par_bit && !sampled_bit;
      w_finish   = sample_valid && !frame_start &&
                   (((r_state == S_STOP1) && !r_stop2) || (r_state == S_STOP2));
      w_brk_f    = (r_state == S_STOP1) ? w_brk_now : r_brk;
      w_par_f    = r_par_bad && !w_brk_f;
      w_stp_f    = (r_stp_bad || w_stop_bad) && !w_brk_f;
   end

   // Frame sequencing, bit assembly and registered per-frame result pulses.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_idx     <= '0;
         r_shift   <= '0;
         r_rx_data <= '0;
         r_par_en  <= 1'b0;
         r_par_odd <= 1'b0;
         r_stop2   <= 1'b0;
         r_par_bit <= 1'b0;
         r_par_bad <= 1'b0;
         r_stp_bad <= 1'b0;
         r_brk     <= 1'b0;
         r_done    <= 1'b0;
         r_valid   <= 1'b0;
         r_par_err <= 1'b0;
         r_stp_err <= 1'b0;
         r_brk_det <= 1'b0;
      end else begin
         r_done    <= 1'b0;
         r_valid   <= 1'b0;
         r_par_err <= 1'b0;
         r_stp_err <= 1'b0;
         r_brk_det <= 1'b0;

         if (frame_start) begin
            // A new start bit always restarts, even mid-frame.
            r_state   <= S_DATA;
            r_idx     <= '0;
            r_shift   <= '0;
            r_par_en  <= cfg_par_en;
            r_par_odd <= cfg_par_odd;
            r_stop2   <= cfg_stop2;
            r_par_bit <= 1'b0;
            r_par_bad <= 1'b0;
            r_stp_bad <= 1'b0;
            r_brk     <= 1'b0;
         end else begin
            case (r_state)
               S_DATA: begin
                  if (sample_valid) begin
                     // LSB arrives first, so shift in from the top.
                     r_shift <= {sampled_bit, r_shift[DATA_W-1:1]};
                     r_idx   <= r_idx + IDX_W'(1);
                     if (r_idx == IDX_W'(DATA_W - 1)) begin
                        r_state <= r_par_en ? S_PARITY : S_STOP1;
                     end
                  end
               end
               S_PARITY: begin
                  if (sample_valid) begin
                     r_par_bit <= sampled_bit;
                     r_par_bad <= parity_mismatch(^r_shift, sampled_bit, r_par_odd);
                     r_state   <= S_STOP1;
                  end
               end
               S_STOP1: begin
                  if (sample_valid) begin
                     r_brk     <= w_brk_now;
                     r_stp_bad <= w_stop_bad;
                     r_state   <= r_stop2 ? S_STOP2 : S_REPORT;
                  end
               end
               S_STOP2: begin
                  if (sample_valid) begin
                     r_state <= S_REPORT;
                  end
               end
               S_REPORT: begin
                  r_state <= S_IDLE;
               end
               default: begin
                  r_state <= S_IDLE;
               end
            endcase

            if (w_finish) begin
               r_done    <= 1'b1;
               r_valid   <= !(w_par_f || w_stp_f || w_brk_f);
               r_par_err <= w_par_f;
               r_stp_err <= w_stp_f;
               r_brk_det <= w_brk_f;
               r_rx_data <= r_shift;
            end
         end
      end
   end

   // Sticky flags latch reported events until cleared; clear has priority.
   always_ff @(posedge clk) begin
      if (rst || clr_stats) begin
         r_par_sticky <= 1'b0;
         r_stp_sticky <= 1'b0;
         r_brk_sticky <= 1'b0;
      end else begin
         if (r_par_err) r_par_sticky <= 1'b1;
         if (r_stp_err) r_stp_sticky <= 1'b1;
         if (r_brk_det) r_brk_sticky <= 1'b1;
      end
   end

   sat_counter #(.CNT_W(CNT_W)) u_par_cnt (
      .clk (clk),
      .rst (rst),
      .inc (r_par_err),
      .clr (clr_stats),
      .cnt (par_err_cnt)
   );

   sat_counter #(.CNT_W(CNT_W)) u_stp_cnt (
      .clk (clk),
      .rst (rst),
      .inc (r_stp_err),
      .clr (clr_stats),
      .cnt (stp_err_cnt)
   );

   sat_counter #(.CNT_W(CNT_W)) u_brk_cnt (
      .clk (clk),
      .rst (rst),
      .inc (r_brk_det),
      .clr (clr_stats),
      .cnt (brk_cnt)
   );

   assign rx_data        = r_rx_data;
   assign frame_done     = r_done;
   assign data_valid     = r_valid;
   assign par_err        = r_par_err;
   assign stp_err        = r_stp_err;
   assign brk_det        = r_brk_det;
   assign par_err_sticky = r_par_sticky;
   assign stp_err_sticky = r_stp_sticky;
   assign brk_sticky     = r_brk_sticky;

endmodule
`default_nettype wire

// File: tb/tb_frame_check.sv
`default_nettype none
// ============================================================================
// Module      : tb_frame_check
// Description : Self-checking bench for frame_check: frame-level reference
//               model compared every cycle, directed frames with literal
//               expectations, and a randomized traffic phase.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_frame_check;

   localparam int DW   = 8;
   localparam int CW   = 2;
   localparam int CMAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          frame_start = 1'b0;
   logic          sample_valid = 1'b0;
   logic          sampled_bit = 1'b0;
   logic          cfg_par_en = 1'b0;
   logic          cfg_par_odd = 1'b0;
   logic          cfg_stop2 = 1'b0;
   logic          clr_stats = 1'b0;
   logic [DW-1:0] rx_data;
   logic          frame_done, data_valid, par_err, stp_err, brk_det;
   logic          par_err_sticky, stp_err_sticky, brk_sticky;
   logic [CW-1:0] par_err_cnt, stp_err_cnt, brk_cnt;

   int n_chk  = 0;
   int n_pass = 0;
   int n_done = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   frame_check #(.DATA_W(DW), .CNT_W(CW)) dut (
      .clk            (clk),
      .rst            (rst),
      .frame_start    (frame_start),
      .sample_valid   (sample_valid),
      .sampled_bit    (sampled_bit),
      .cfg_par_en     (cfg_par_en),
      .cfg_par_odd    (cfg_par_odd),
      .cfg_stop2      (cfg_stop2),
      .clr_stats      (clr_stats),
      .rx_data        (rx_data),
      .frame_done     (frame_done),
      .data_valid     (data_valid),
      .par_err        (par_err),
      .stp_err        (stp_err),
      .brk_det        (brk_det),
      .par_err_sticky (par_err_sticky),
      .stp_err_sticky (stp_err_sticky),
      .brk_sticky     (brk_sticky),
      .par_err_cnt    (par_err_cnt),
      .stp_err_cnt    (stp_err_cnt),
      .brk_cnt        (brk_cnt)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
   endtask

   // ---------------- frame-level reference model ----------------
   bit            m_active;
   bit            m_q[$];
   bit            m_pen, m_podd, m_st2;
   logic [DW-1:0] m_rx;
   bit            m_done, m_valid, m_par, m_stp, m_brk;
   bit            ms_par, ms_stp, ms_brk;
   int            mc_par, mc_stp, mc_brk;
   logic [DW-1:0] e_d;
   int            e_ones, e_k;
   bit            e_pb, e_s1, e_s2, e_bad;

   function automatic int sat_inc(input int c);
      return (c < CMAX) ? c + 1 : c;
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         m_active = 0; m_q.delete();
         m_pen = 0; m_podd = 0; m_st2 = 0;
         m_rx = '0;
         m_done = 0; m_valid = 0; m_par = 0; m_stp = 0; m_brk = 0;
         ms_par = 0; ms_stp = 0; ms_brk = 0;
         mc_par = 0; mc_stp = 0; mc_brk = 0;
      end else begin
         // statistics react to the results reported in the previous cycle
         if (clr_stats) begin
            ms_par = 0; ms_stp = 0; ms_brk = 0;
            mc_par = 0; mc_stp = 0; mc_brk = 0;
         end else begin
            if (m_par) begin ms_par = 1; mc_par = sat_inc(mc_par); end
            if (m_stp) begin ms_stp = 1; mc_stp = sat_inc(mc_stp); end
            if (m_brk) begin ms_brk = 1; mc_brk = sat_inc(mc_brk); end
         end
         m_done = 0; m_valid = 0; m_par = 0; m_stp = 0; m_brk = 0;
         if (frame_start) begin
            m_active = 1; m_q.delete();
            m_pen = cfg_par_en; m_podd = cfg_par_odd; m_st2 = cfg_stop2;
         end else if (m_active && sample_valid) begin
            m_q.push_back(sampled_bit);
            if (m_q.size() == DW + int'(m_pen) + 1 + int'(m_st2)) begin
               e_ones = 0;
               for (int i = 0; i < DW; i++) begin
                  e_d[i] = m_q[i];
                  e_ones += int'(m_q[i]);
               end
               e_k = DW; e_pb = 0; e_bad = 0; e_s2 = 1;
               if (m_pen) begin
                  e_pb = m_q[e_k];
                  e_ones += int'(e_pb);
                  e_bad = ((e_ones % 2) != int'(m_podd));
                  e_k++;
               end
               e_s1 = m_q[e_k];
               if (m_st2) e_s2 = m_q[e_k + 1];
               m_brk   = (e_d == '0) && !e_pb && !e_s1;
               m_par   = e_bad && !m_brk;
               m_stp   = (!e_s1 || !e_s2) && !m_brk;
               m_valid = !(m_brk || m_par || m_stp);
               m_done  = 1;
               m_rx    = e_d;
               m_active = 0;
            end
         end
      end
   end

   // Compare every DUT output against the model each cycle.
   always @(negedge clk) begin
      if (chk_en) begin
         if (frame_done === 1'b1) n_done++;
         chk("frame_done", 32'(frame_done), 32'(m_done));
         chk("data_valid", 32'(data_valid), 32'(m_valid));
         chk("par_err", 32'(par_err), 32'(m_par));
         chk("stp_err", 32'(stp_err), 32'(m_stp));
         chk("brk_det", 32'(brk_det), 32'(m_brk));
         chk("rx_data", 32'(rx_data), 32'(m_rx));
         chk("par_sticky", 32'(par_err_sticky), 32'(ms_par));
         chk("stp_sticky", 32'(stp_err_sticky), 32'(ms_stp));
         chk("brk_sticky", 32'(brk_sticky), 32'(ms_brk));
         chk("par_cnt", 32'(par_err_cnt), 32'(mc_par));
         chk("stp_cnt", 32'(stp_err_cnt), 32'(mc_stp));
         chk("brk_cnt", 32'(brk_cnt), 32'(mc_brk));
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic put_sample(input bit b);
      sample_valid = 1'b1;
      sampled_bit  = b;
      tick();
      sample_valid = 1'b0;
      sampled_bit  = 1'($urandom);
   endtask

   // Sends a full frame; returns in the cycle where frame_done should show.
   task automatic send_frame(input logic [DW-1:0] d, input bit pen, input bit podd,
                             input bit st2, input bit force_p, input bit pval,
                             input bit s1, input bit s2);
      bit bits[$];
      bit p;
      cfg_par_en = pen; cfg_par_odd = podd; cfg_stop2 = st2;
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      // configuration must have been captured at the start strobe
      cfg_par_en = 1'($urandom); cfg_par_odd = 1'($urandom); cfg_stop2 = 1'($urandom);
      for (int i = 0; i < DW; i++) bits.push_back(d[i]);
      p = force_p ? pval : ((^d) ^ podd);
      if (pen) bits.push_back(p);
      bits.push_back(s1);
      if (st2) bits.push_back(s2);
      for (int i = 0; i < bits.size(); i++) begin
         repeat ($urandom_range(0, 2)) tick();
         if (i == bits.size() - 1) chk("pre_done", 32'(frame_done), 32'h0);
         put_sample(bits[i]);
      end
      chk("done_latency", 32'(frame_done), 32'h1);
   endtask

   task automatic random_phase(input int cycles);
      bit zmode;
      zmode = 1'b0;
      for (int c = 0; c < cycles; c++) begin
         frame_start = ($urandom_range(0, 79) == 0);
         if (frame_start) zmode = ($urandom_range(0, 3) == 0);
         sample_valid = ($urandom_range(0, 2) == 0);
         sampled_bit  = zmode ? ($urandom_range(0, 15) == 0) : 1'($urandom_range(0, 1));
         cfg_par_en   = 1'($urandom_range(0, 1));
         cfg_par_odd  = 1'($urandom_range(0, 1));
         cfg_stop2    = 1'($urandom_range(0, 1));
         clr_stats    = ($urandom_range(0, 99) == 0);
         rst          = ($urandom_range(0, 2999) == 0);
         tick();
      end
      frame_start = 0; sample_valid = 0; clr_stats = 0; rst = 0;
   endtask

   logic [DW-1:0] v5a;
   int base_done;

   initial begin
      repeat (3) tick();
      rst = 1'b0;
      chk_en = 1'b1;
      // reset state
      chk("rst_rx", 32'(rx_data), 32'h0);
      chk("rst_done", 32'(frame_done), 32'h0);
      chk("rst_cnt", 32'({par_err_cnt, stp_err_cnt, brk_cnt}), 32'h0);

      // 8N1 0xA5
      send_frame(8'hA5, 0, 0, 0, 0, 0, 1, 1);
      chk("a5_rx", 32'(rx_data), 32'hA5);
      chk("a5_valid", 32'(data_valid), 32'h1);
      chk("a5_errs", 32'({par_err, stp_err, brk_det}), 32'h0);
      tick();

      // 8E1 0x07 with wrong parity bit 0
      send_frame(8'h07, 1, 0, 0, 1, 0, 1, 1);
      chk("par_err", 32'(par_err), 32'h1);
      chk("par_valid", 32'(data_valid), 32'h0);
      tick();
      chk("par_cnt1", 32'(par_err_cnt), 32'h1);
      chk("par_sticky1", 32'(par_err_sticky), 32'h1);

      // 8N2 0x3C, second stop bit bad
      send_frame(8'h3C, 0, 0, 1, 0, 0, 1, 0);
      chk("stp2_err", 32'(stp_err), 32'h1);
      tick();
      chk("stp_cnt1", 32'(stp_err_cnt), 32'h1);

      // 8E1 all zero -> break
      send_frame(8'h00, 1, 0, 0, 1, 0, 0, 0);
      chk("brk_det", 32'(brk_det), 32'h1);
      chk("brk_masks", 32'({par_err, stp_err}), 32'h0);
      tick();
      chk("brk_cnt1", 32'(brk_cnt), 32'h1);

      // three more stop errors: four total saturate a 2-bit counter at 3
      repeat (3) begin
         send_frame(8'h11, 0, 0, 0, 0, 0, 0, 1);
         tick();
      end
      chk("stp_sat", 32'(stp_err_cnt), 32'h3);

      // fifth stop error with coincident clear
      send_frame(8'h11, 0, 0, 0, 0, 0, 0, 1);
      chk("stp5_err", 32'(stp_err), 32'h1);
      clr_stats = 1'b1;
      tick();
      clr_stats = 1'b0;
      chk("clr_cnt", 32'(stp_err_cnt), 32'h0);
      chk("clr_sticky", 32'(stp_err_sticky), 32'h0);

      // reset after 4 data bits discards the frame
      v5a = 8'h5A;
      base_done = n_done;
      cfg_par_en = 0; cfg_par_odd = 0; cfg_stop2 = 0;
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      for (int i = 0; i < 4; i++) put_sample(v5a[i]);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int i = 4; i < DW; i++) put_sample(v5a[i]);
      put_sample(1'b1);
      repeat (3) tick();
      chk("rst_no_done", 32'(n_done - base_done), 32'h0);
      send_frame(8'h5A, 0, 0, 0, 0, 0, 1, 1);
      chk("5a_rx", 32'(rx_data), 32'h5A);
      chk("5a_valid", 32'(data_valid), 32'h1);
      tick();

      random_phase(20000);
      repeat (4) tick();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/frame_check.md
FRAME_CHECK -- requirements
Module: frame_check

Interface
REQ-001 Parameter DATA_W, 8, data bits per frame (legal 5..9).
REQ-002 Parameter CNT_W, 8, width of each error counter.
REQ-003 clk  input  1  single clock; all logic on posedge clk.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 frame_start  input  1  one-cycle strobe: start bit accepted by the sampler.
REQ-006 sample_valid  input  1  one-cycle strobe: sampled_bit holds the next frame bit.
REQ-007 sampled_bit  input  1  majority-voted bit value from the sampler.
REQ-008 cfg_par_en  input  1  parity bit present.
REQ-009 cfg_par_odd  input  1  1 = odd parity, 0 = even.
REQ-010 cfg_stop2  input  1  1 = two stop bits, 0 = one.
REQ-011 clr_stats  input  1  one-cycle strobe: clear counters and sticky flags.
REQ-012 rx_data  output  DATA_W  assembled data word, LSB received first.
REQ-013 frame_done  output  1  one-cycle pulse: frame finished (any outcome).
REQ-014 data_valid  output  1  one-cycle pulse with frame_done when the frame has no error and no break.
REQ-015 par_err / stp_err / brk_det  output  1 each  per-frame result pulses, qualified by frame_done.
REQ-016 par_err_sticky / stp_err_sticky / brk_sticky  output  1 each  latched flags until clr_stats.
REQ-017 par_err_cnt / stp_err_cnt / brk_cnt  output  CNT_W each  saturating event counters.

Function
REQ-018 FSM states SHALL be IDLE, DATA, PARITY, STOP1, STOP2, REPORT.
REQ-019 IDLE -> DATA on frame_start; bit index cleared; cfg_par_en, cfg_par_odd, cfg_stop2 latched that cycle and held for the frame.
REQ-020 In DATA each sample_valid SHALL shift sampled_bit into the word at the current index (LSB first) and increment the index.
REQ-021 After the DATA_W-th data sample, next state SHALL be PARITY if latched par_en, else STOP1.
REQ-022 PARITY on sample_valid: error if XOR(data, parity bit) != latched par_odd; -> STOP1.
REQ-023 STOP1 on sample_valid: error if bit = 0; -> STOP2 if latched stop2, else REPORT.
REQ-024 STOP2 on sample_valid: error if bit = 0; -> REPORT.
REQ-025 Stop error SHALL be the OR of STOP1 and STOP2 checks.
REQ-026 Break: all data bits 0, parity bit 0 (if present), STOP1 bit 0; then brk_det=1 and par_err=stp_err=0 for that frame.
REQ-027 REPORT lasts exactly one cycle, drives frame_done=1 and result pulses, -> IDLE; latency = one cycle after the final stop sample_valid.
REQ-028 data_valid = frame_done AND NOT(par_err OR stp_err OR brk_det).
REQ-029 rx_data SHALL update only in REPORT and hold between frames.
REQ-030 States without a pending sample SHALL ignore sampled_bit; sample_valid in IDLE or REPORT is ignored.
REQ-031 frame_start outside IDLE SHALL abort the current frame without reporting and restart in DATA; takes priority over a coincident sample_valid.
REQ-032 Each counter SHALL increment by one per reported event and saturate at all-ones.
REQ-033 clr_stats SHALL clear counters and sticky flags; it wins over a coincident increment/set.

Reset
REQ-034 rst SHALL force IDLE, bit index 0, rx_data 0, all pulses, sticky flags and counters 0, latched config 0.
REQ-035 rst mid-frame SHALL discard the frame with no frame_done.

Structure
REQ-036 State encoding and the default DATA_W and CNT_W values SHALL live in a shared uart package.
REQ-037 One sub-module sat_counter (CNT_W, inc, clr) SHALL be instantiated three times; all else in frame_check.

Verification
REQ-038 8N1, data 0xA5, stop 1 -> frame_done+data_valid, rx_data=0xA5, no errors, 1 cycle after stop sample.
REQ-039 8E1, data 0x07, parity bit 0 -> par_err=1, data_valid=0, par_err_cnt=1, par_err_sticky=1.
REQ-040 8N2, data 0x3C, STOP1=1, STOP2=0 -> stp_err=1, stp_err_cnt=1.
REQ-041 8E1 all zeros incl. parity and stop -> brk_det=1, par_err=stp_err=0, brk_cnt=1.
REQ-042 CNT_W=2, four stop errors -> stp_err_cnt=3; clr_stats coincident with fifth error -> counter 0, sticky 0.
REQ-043 rst asserted after 4 data bits -> no frame_done; next 8N1 frame 0x5A received correctly.
